// File: rtl/trivium_decrypt_if.sv
// trivium_decrypt_if: ciphertext-in / plaintext-out stream bundle for the
// Trivium receive block. The master side is the link receiver plus the consumer;
// the slave side is the decrypt block.
interface trivium_decrypt_if #(
  parameter int W = 8
) ();
  logic         ct_valid;
  logic [W-1:0] ct_data;
  logic         ct_ready;
  logic         pt_valid;
  logic [W-1:0] pt_data;
  logic         pt_ready;

  modport master (
    output ct_valid,
    output ct_data,
    output pt_ready,
    input  ct_ready,
    input  pt_valid,
    input  pt_data
  );

  modport slave (
    input  ct_valid,
    input  ct_data,
    input  pt_ready,
    output ct_ready,
    output pt_valid,
    output pt_data
  );
endinterface

// File: rtl/trivium_decrypt.sv
// trivium_decrypt: receive-side Trivium stream cipher. Loads key/IV on start,
// runs the warm-up with W rounds per cycle, then XORs each accepted ciphertext
// word with W keystream bits (bit 0 earliest) and presents registered plaintext.
// Optional build macro TRIVIUM_WORD_CNT_EN adds a saturating 32-bit word_cnt
// output counting words accepted since the last start.
module trivium_decrypt #(
  parameter int W             = 8,
  parameter int WARMUP_ROUNDS = 1152
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [79:0]      key,
  input  logic [79:0]      iv,
  output logic             busy,
  trivium_decrypt_if.slave bus
`ifdef TRIVIUM_WORD_CNT_EN
  ,
  output logic [31:0]      word_cnt
`endif
);

  localparam int WARM_CYCLES = WARMUP_ROUNDS / W;
  localparam int CNT_W       = (WARM_CYCLES > 1) ? $clog2(WARM_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t             state_r;
  state_t             next_state_s;
  logic               busy_r;
  logic [287:0]       s_r;
  logic [287:0]       s_next_s;
  logic [W-1:0]       z_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               warm_done_s;
  logic               pt_valid_r;
  logic [W-1:0]       pt_data_r;
  logic               ct_ready_s;
  logic               accept_s;
  logic [287:0]       load_s;

  // s_r[i-1] holds s_i: key in s1..s80, IV in s94..s173, ones in s286..s288.
  assign load_s      = {3'b111, 108'd0, 4'd0, iv, 13'd0, key};
  assign warm_done_s = (cnt_r == CNT_W'(WARM_CYCLES - 1));

  // State register; busy mirrors the state being entered so it is a flop output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s == ST_WARMUP);
    end
  end

  // Next-state logic: start restarts from any state, warm-up ends into RUN.
  always_comb begin
    next_state_s = state_r;
    if (start) begin
      next_state_s = ST_WARMUP;
    end else begin
      case (state_r)
        ST_IDLE:   next_state_s = ST_IDLE;
        ST_WARMUP: begin
          if (warm_done_s) begin
            next_state_s = ST_RUN;
          end else begin
            next_state_s = ST_WARMUP;
          end
        end
        ST_RUN:    next_state_s = ST_RUN;
        default:   next_state_s = ST_IDLE;
      endcase
    end
  end

  // Handshake decode: ciphertext is taken only in RUN when the output slot frees up.
  always_comb begin
    ct_ready_s = 1'b0;
    accept_s   = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (start) begin
          ct_ready_s = 1'b0;
        end else begin
          ct_ready_s = !pt_valid_r || bus.pt_ready;
        end
        accept_s = ct_ready_s && bus.ct_valid;
      end
      ST_IDLE, ST_WARMUP: begin
        ct_ready_s = 1'b0;
        accept_s   = 1'b0;
      end
      default: begin
        ct_ready_s = 1'b0;
        accept_s   = 1'b0;
      end
    endcase
  end

  // Unrolled keystream: W Trivium rounds from the current state, z_s[j] from round j.
  always_comb begin : ks_gen
    logic t1, t2, t3;
    t1       = 1'b0;
    t2       = 1'b0;
    t3       = 1'b0;
    s_next_s = s_r;
    z_s      = {W{1'b0}};
    for (int j = 0; j < W; j++) begin
      t1     = s_next_s[65]  ^ s_next_s[92];
      t2     = s_next_s[161] ^ s_next_s[176];
      t3     = s_next_s[242] ^ s_next_s[287];
      z_s[j] = t1 ^ t2 ^ t3;
      t1     = t1 ^ (s_next_s[90]  & s_next_s[91])  ^ s_next_s[170];
      t2     = t2 ^ (s_next_s[174] & s_next_s[175]) ^ s_next_s[263];
      t3     = t3 ^ (s_next_s[285] & s_next_s[286]) ^ s_next_s[68];
      s_next_s = {s_next_s[286:177], t2, s_next_s[175:93], t1, s_next_s[91:0], t3};
    end
  end

  // Cipher state, warm-up counter and plaintext register; state advances only when used.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_r        <= 288'd0;
      cnt_r      <= {CNT_W{1'b0}};
      pt_valid_r <= 1'b0;
      pt_data_r  <= {W{1'b0}};
    end else if (start) begin
      s_r        <= load_s;
      cnt_r      <= {CNT_W{1'b0}};
      pt_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_WARMUP: begin
          s_r   <= s_next_s;
          cnt_r <= cnt_r + CNT_W'(1);
        end
        ST_RUN: begin
          if (accept_s) begin
            s_r        <= s_next_s;
            pt_data_r  <= bus.ct_data ^ z_s;
            pt_valid_r <= 1'b1;
          end else if (bus.pt_ready) begin
            pt_valid_r <= 1'b0;
          end else begin
            pt_valid_r <= pt_valid_r;
          end
        end
        default: begin
          s_r <= s_r;
        end
      endcase
    end
  end

`ifdef TRIVIUM_WORD_CNT_EN
  logic [31:0] word_cnt_r;

  // Saturating count of ciphertext words accepted since the last start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_cnt_r <= 32'd0;
    end else if (start) begin
      word_cnt_r <= 32'd0;
    end else if (accept_s && (word_cnt_r != 32'hFFFF_FFFF)) begin
      word_cnt_r <= word_cnt_r + 32'd1;
    end else begin
      word_cnt_r <= word_cnt_r;
    end
  end

  assign word_cnt = word_cnt_r;
`endif

  assign busy         = busy_r;
  assign bus.ct_ready = ct_ready_s;
  assign bus.pt_valid = pt_valid_r;
  assign bus.pt_data  = pt_data_r;

endmodule

// File: tb/tb_trivium_decrypt.sv
// tb_trivium_decrypt: directed bench for trivium_decrypt (W = 8). Expected
// plaintext comes from a bit-serial Trivium model kept in the bench.
module tb_trivium_decrypt;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [79:0] key;
  logic [79:0] iv;
  logic        busy;
`ifdef TRIVIUM_WORD_CNT_EN
  logic [31:0] word_cnt;
`endif

  trivium_decrypt_if #(.W(8)) bus ();

  trivium_decrypt #(.W(8), .WARMUP_ROUNDS(1152)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .key   (key),
    .iv    (iv),
    .busy  (busy),
    .bus   (bus)
`ifdef TRIVIUM_WORD_CNT_EN
    ,
    .word_cnt (word_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:288] m;
  logic [7:0]   ct_q[$];
  logic [7:0]   exp_q[$];

  // ---------------- bit-serial reference model ----------------
  task automatic model_load(input logic [79:0] k, input logic [79:0] v);
    for (int i = 1; i <= 288; i++) m[i] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      m[i]      = k[i-1];
      m[93 + i] = v[i-1];
    end
    m[286] = 1'b1;
    m[287] = 1'b1;
    m[288] = 1'b1;
  endtask

  task automatic model_round(output logic z);
    logic a, b, c;
    a = m[66] ^ m[93];
    b = m[162] ^ m[177];
    c = m[243] ^ m[288];
    z = a ^ b ^ c;
    a = a ^ (m[91] & m[92]) ^ m[171];
    b = b ^ (m[175] & m[176]) ^ m[264];
    c = c ^ (m[286] & m[287]) ^ m[69];
    for (int k = 288; k >= 179; k--) m[k] = m[k-1];
    m[178] = b;
    for (int k = 177; k >= 95; k--) m[k] = m[k-1];
    m[94] = a;
    for (int k = 93; k >= 2; k--) m[k] = m[k-1];
    m[1] = c;
  endtask

  task automatic model_init(input logic [79:0] k, input logic [79:0] v);
    logic zd;
    model_load(k, v);
    for (int r = 0; r < 1152; r++) model_round(zd);
  endtask

  task automatic model_byte(output logic [7:0] b);
    logic zb;
    for (int j = 0; j < 8; j++) begin
      model_round(zb);
      b[j] = zb;
    end
  endtask

  // mode 0: ciphertext all zero, plaintext = keystream; mode 1: random plaintext encrypted
  task automatic build_stream(input int n, input int mode);
    logic [7:0] ks, p;
    ct_q.delete();
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      model_byte(ks);
      if (mode == 0) begin
        ct_q.push_back(8'h00);
        exp_q.push_back(ks);
      end else begin
        p = 8'($urandom_range(0, 255));
        ct_q.push_back(p ^ ks);
        exp_q.push_back(p);
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic do_start(input logic [79:0] k, input logic [79:0] v);
    @(negedge clk);
    key   = k;
    iv    = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_warmup(output int n, output int rdy_bad);
    n = 0;
    rdy_bad = 0;
    #1;
    while (busy === 1'b1 && n < 2000) begin
      n++;
      if (bus.ct_ready !== 1'b0) rdy_bad++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic run_stream(input string name, input int stall_at, input int stall_len,
                            output int cycles);
    int in_idx, out_idx, budget;
    in_idx  = 0;
    out_idx = 0;
    cycles  = 0;
    budget  = ct_q.size() + stall_len + 50;
    while (out_idx < exp_q.size() && cycles < budget) begin
      @(negedge clk);
      bus.pt_ready = !(cycles >= stall_at && cycles < stall_at + stall_len);
      if (in_idx < ct_q.size()) begin
        bus.ct_valid = 1'b1;
        bus.ct_data  = ct_q[in_idx];
      end else begin
        bus.ct_valid = 1'b0;
        bus.ct_data  = 8'h00;
      end
      #1;
      if (bus.pt_valid === 1'b1) begin
        n_checks++;
        if (bus.pt_data !== exp_q[out_idx]) begin
          n_fail++;
          $display("FAIL %s word %0d: pt_data=%h expected %h", name, out_idx, bus.pt_data, exp_q[out_idx]);
        end
        if (bus.pt_ready === 1'b0) begin
          n_checks++;
          if (bus.ct_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s stall ct_ready: got %b expected 0", name, bus.ct_ready);
          end
        end else begin
          out_idx++;
        end
      end
      if (bus.ct_valid === 1'b1 && bus.ct_ready === 1'b1) in_idx++;
      cycles++;
    end
    if (out_idx < exp_q.size()) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: %0d of %0d words seen", name, out_idx, exp_q.size());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset = 1'b0;
    start = 1'b0;
    key = 80'h0;
    iv = 80'h0;
    bus.ct_valid = 1'b0;
    bus.ct_data = 8'h00;
    bus.pt_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy); end
    n_checks++; if (bus.ct_ready !== 1'b0) begin n_fail++; $display("FAIL reset ct_ready: got %b expected 0", bus.ct_ready); end
    n_checks++; if (bus.pt_valid !== 1'b0) begin n_fail++; $display("FAIL reset pt_valid: got %b expected 0", bus.pt_valid); end
    n_checks++; if (bus.pt_data !== 8'h00) begin n_fail++; $display("FAIL reset pt_data: got %h expected 00", bus.pt_data); end
    reset = 1'b1;
    bus.ct_valid = 1'b1;
    bus.pt_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (bus.ct_ready !== 1'b0) begin n_fail++; $display("FAIL idle ct_ready: got %b expected 0", bus.ct_ready); end
    n_checks++; if (bus.pt_valid !== 1'b0) begin n_fail++; $display("FAIL idle pt_valid: got %b expected 0", bus.pt_valid); end
    bus.ct_valid = 1'b0;
  endtask

  task automatic test_warmup;
    int n, bad;
    model_init(80'h0, 80'h0);
    do_start(80'h0, 80'h0);
    wait_warmup(n, bad);
    n_checks++; if (n !== 144) begin n_fail++; $display("FAIL warmup busy cycles: got %0d expected 144", n); end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL warmup ct_ready high in %0d cycles, expected 0", bad); end
    n_checks++; if (bus.ct_ready !== 1'b1) begin n_fail++; $display("FAIL warmup end ct_ready: got %b expected 1", bus.ct_ready); end
  endtask

  task automatic test_keystream;
    int cyc;
    build_stream(64, 0);
    run_stream("keystream", 1000, 0, cyc);
    n_checks++; if (cyc !== 65) begin n_fail++; $display("FAIL keystream cycles: got %0d expected 65", cyc); end
  endtask

  task automatic test_round_trip;
    int n, bad, cyc;
    logic [95:0] r;
    logic [79:0] k, v;
    r = {$urandom(), $urandom(), $urandom()};
    k = r[79:0];
    r = {$urandom(), $urandom(), $urandom()};
    v = r[79:0];
    model_init(k, v);
    do_start(k, v);
    wait_warmup(n, bad);
    n_checks++; if (n !== 144) begin n_fail++; $display("FAIL round_trip warmup: got %0d expected 144", n); end
    build_stream(256, 1);
    run_stream("round_trip", 1000, 0, cyc);
    n_checks++; if (cyc !== 257) begin n_fail++; $display("FAIL round_trip cycles: got %0d expected 257", cyc); end
  endtask

  task automatic test_backpressure;
    int cyc;
    build_stream(40, 1);
    run_stream("backpressure", 10, 10, cyc);
    n_checks++; if (cyc !== 51) begin n_fail++; $display("FAIL backpressure cycles: got %0d expected 51", cyc); end
  endtask

  task automatic test_restart;
    int n, bad, cyc;
    do_start(80'h0123_4567_89AB_CDEF_0011, 80'h1111_2222_3333_4444_5555);
    wait_warmup(n, bad);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.pt_ready = 1'b1;
      bus.ct_valid = 1'b1;
      bus.ct_data  = 8'(i);
    end
    @(negedge clk);
    bus.pt_ready = 1'b0;
    bus.ct_data  = 8'h55;
    key   = 80'hFEDC_BA98_7654_3210_A5A5;
    iv    = 80'h0F0F_F0F0_0F0F_F0F0_3C3C;
    start = 1'b1;
    #1;
    n_checks++; if (bus.pt_valid !== 1'b1) begin n_fail++; $display("FAIL restart pending pt_valid: got %b expected 1", bus.pt_valid); end
    n_checks++; if (bus.ct_ready !== 1'b0) begin n_fail++; $display("FAIL restart ct_ready: got %b expected 0", bus.ct_ready); end
    @(negedge clk);
    start = 1'b0;
    bus.ct_valid = 1'b0;
    #1;
    n_checks++; if (bus.pt_valid !== 1'b0) begin n_fail++; $display("FAIL restart pt_valid drop: got %b expected 0", bus.pt_valid); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL restart busy: got %b expected 1", busy); end
    wait_warmup(n, bad);
    n_checks++; if (n !== 144) begin n_fail++; $display("FAIL restart warmup: got %0d expected 144", n); end
    model_init(80'hFEDC_BA98_7654_3210_A5A5, 80'h0F0F_F0F0_0F0F_F0F0_3C3C);
    build_stream(16, 0);
    run_stream("restart", 1000, 0, cyc);
  endtask

  task automatic test_start_collision;
    int n, bad, cyc;
    @(negedge clk);
    bus.pt_ready = 1'b1;
    bus.ct_valid = 1'b1;
    bus.ct_data  = 8'hAA;
    key   = 80'h5A5A_0000_FFFF_1234_9876;
    iv    = 80'hC0DE_CAFE_BEEF_0000_0001;
    start = 1'b1;
    #1;
    n_checks++; if (bus.ct_ready !== 1'b0) begin n_fail++; $display("FAIL collision ct_ready: got %b expected 0", bus.ct_ready); end
    @(negedge clk);
    start = 1'b0;
    bus.ct_valid = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL collision busy: got %b expected 1", busy); end
    n_checks++; if (bus.pt_valid !== 1'b0) begin n_fail++; $display("FAIL collision pt_valid: got %b expected 0", bus.pt_valid); end
    wait_warmup(n, bad);
    model_init(80'h5A5A_0000_FFFF_1234_9876, 80'hC0DE_CAFE_BEEF_0000_0001);
    build_stream(8, 1);
    run_stream("collision", 1000, 0, cyc);
  endtask

  task automatic test_warmup_restart;
    int n, bad, cyc;
    do_start(80'h1, 80'h2);
    repeat (50) @(negedge clk);
    do_start(80'hABCD_EF01_2345_6789_0ACE, 80'h9999_8888_7777_6666_5555);
    wait_warmup(n, bad);
    n_checks++; if (n !== 144) begin n_fail++; $display("FAIL warmup_restart cycles: got %0d expected 144", n); end
    model_init(80'hABCD_EF01_2345_6789_0ACE, 80'h9999_8888_7777_6666_5555);
    build_stream(8, 0);
    run_stream("warmup_restart", 1000, 0, cyc);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    bus.pt_ready = 1'b0;
    bus.ct_valid = 1'b1;
    bus.ct_data  = 8'h3C;
    @(negedge clk);
    bus.ct_valid = 1'b0;
    #1;
    n_checks++; if (bus.pt_valid !== 1'b1) begin n_fail++; $display("FAIL reset_mid pre pt_valid: got %b expected 1", bus.pt_valid); end
    reset = 1'b0;
    #1;
    n_checks++; if (bus.pt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid pt_valid: got %b expected 0", bus.pt_valid); end
    n_checks++; if (bus.pt_data !== 8'h00) begin n_fail++; $display("FAIL reset_mid pt_data: got %h expected 00", bus.pt_data); end
    n_checks++; if (bus.ct_ready !== 1'b0) begin n_fail++; $display("FAIL reset_mid ct_ready: got %b expected 0", bus.ct_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid busy: got %b expected 0", busy); end
    @(negedge clk);
    reset = 1'b1;
    bus.ct_valid = 1'b1;
    bus.pt_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (bus.ct_ready !== 1'b0) begin n_fail++; $display("FAIL reset_mid idle ct_ready: got %b expected 0", bus.ct_ready); end
    bus.ct_valid = 1'b0;
  endtask

`ifdef TRIVIUM_WORD_CNT_EN
  task automatic test_word_cnt;
    int n, bad, cyc;
    model_init(80'h77, 80'h88);
    do_start(80'h77, 80'h88);
    wait_warmup(n, bad);
    build_stream(300, 0);
    run_stream("word_cnt", 1000, 0, cyc);
    @(negedge clk);
    #1;
    n_checks++; if (word_cnt !== 32'd300) begin n_fail++; $display("FAIL word_cnt 300: got %0d expected 300", word_cnt); end
    do_start(80'h99, 80'hAA);
    #1;
    n_checks++; if (word_cnt !== 32'd0) begin n_fail++; $display("FAIL word_cnt clear: got %0d expected 0", word_cnt); end
    wait_warmup(n, bad);
    force dut.word_cnt_r = 32'hFFFF_FFFE;
    #1;
    release dut.word_cnt_r;
    model_init(80'h99, 80'hAA);
    build_stream(3, 0);
    run_stream("word_cnt_sat", 1000, 0, cyc);
    @(negedge clk);
    #1;
    n_checks++; if (word_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL word_cnt saturate: got %h expected ffffffff", word_cnt); end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_warmup();
    test_keystream();
    test_round_trip();
    test_backpressure();
    test_restart();
    test_start_collision();
    test_warmup_restart();
    test_reset_mid();
`ifdef TRIVIUM_WORD_CNT_EN
    test_word_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
